// File: rtl/sram_sp_arbiter.sv
// Round-robin write/read arbiter and command sequencer for a single-port line-buffer SRAM.
// Grants are combinational; SRAM pins are registered; reads return 3 cycles after acceptance.
module sram_sp_arbiter #(
    parameter int unsigned ADDR  = 12,
    parameter int unsigned DEPTH = 2336,
    parameter int unsigned DATA  = 40
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            mbist_busy,
    input  logic            wr_req,
    input  logic [ADDR-1:0] wr_addr,
    input  logic [DATA-1:0] wr_data,
    output logic            wr_gnt,
    input  logic            rd_req,
    input  logic [ADDR-1:0] rd_addr,
    output logic            rd_gnt,
    output logic            rd_vld,
    output logic [DATA-1:0] rd_data,
    output logic            CEN,
    output logic            WEN,
    output logic [ADDR-1:0] A,
    output logic [DATA-1:0] D,
    input  logic [DATA-1:0] Q,
    output logic            err_addr,
    input  logic            err_clr
);

    localparam logic [ADDR-1:0] DepthA = ADDR'(DEPTH);

    logic            last_q, last_d;
    logic            boot_q;
    logic            cen_q, cen_d;
    logic            wen_q, wen_d;
    logic [ADDR-1:0] a_q, a_d;
    logic [DATA-1:0] d_q, d_d;
    logic            p1_vld_q, p1_oor_q;
    logic            p2_vld_q, p2_oor_q;
    logic            rd_vld_q;
    logic [DATA-1:0] rd_data_q, rd_data_d;
    logic            err_q, err_d;

    logic wr_oor, rd_oor;
    logic gnt_en, wr_gnt_c, rd_gnt_c;

    assign wr_oor = (wr_addr >= DepthA);
    assign rd_oor = (rd_addr >= DepthA);

    // boot_q suppresses grants in the cycle reset is released.
    assign gnt_en   = !rst && !boot_q && !mbist_busy;
    assign wr_gnt_c = gnt_en && wr_req && (!rd_req || !last_q);
    assign rd_gnt_c = gnt_en && rd_req && (!wr_req || last_q);

    always_comb begin
        cen_d = 1'b1;
        wen_d = 1'b1;
        a_d   = '0;
        d_d   = '0;
        if (wr_gnt_c && !wr_oor) begin
            cen_d = 1'b0;
            wen_d = 1'b0;
            a_d   = wr_addr;
            d_d   = wr_data;
        end else if (rd_gnt_c && !rd_oor) begin
            cen_d = 1'b0;
            a_d   = rd_addr;
        end
    end

    always_comb begin
        last_d = last_q;
        if (wr_gnt_c) begin
            last_d = 1'b1;
        end else if (rd_gnt_c) begin
            last_d = 1'b0;
        end
    end

    always_comb begin
        err_d = err_q;
        if ((wr_gnt_c && wr_oor) || (rd_gnt_c && rd_oor)) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // Out-of-range reads return zero instead of whatever Q holds.
    always_comb begin
        rd_data_d = rd_data_q;
        if (p2_vld_q) begin
            rd_data_d = p2_oor_q ? '0 : Q;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            last_q    <= 1'b1;
            boot_q    <= 1'b1;
            cen_q     <= 1'b1;
            wen_q     <= 1'b1;
            a_q       <= '0;
            d_q       <= '0;
            p1_vld_q  <= 1'b0;
            p1_oor_q  <= 1'b0;
            p2_vld_q  <= 1'b0;
            p2_oor_q  <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            last_q    <= last_d;
            boot_q    <= 1'b0;
            cen_q     <= cen_d;
            wen_q     <= wen_d;
            a_q       <= a_d;
            d_q       <= d_d;
            p1_vld_q  <= rd_gnt_c;
            p1_oor_q  <= rd_gnt_c && rd_oor;
            p2_vld_q  <= p1_vld_q;
            p2_oor_q  <= p1_oor_q;
            rd_vld_q  <= p2_vld_q;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
        end
    end

    assign wr_gnt   = wr_gnt_c;
    assign rd_gnt   = rd_gnt_c;
    assign rd_vld   = rd_vld_q;
    assign rd_data  = rd_data_q;
    assign CEN      = cen_q;
    assign WEN      = wen_q;
    assign A        = a_q;
    assign D        = d_q;
    assign err_addr = err_q;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Directed bench for sram_sp_arbiter: stimulus pushes expected pins/read data into queues,
// a negedge monitor pops and compares against the DUT and a behavioural SRAM.
module tb_sram_sp_arbiter;

    localparam int unsigned ADDR  = 12;
    localparam int unsigned DEPTH = 2336;
    localparam int unsigned DATA  = 40;

    logic            CLK = 1'b0;
    logic            rst = 1'b1;
    logic            mbist_busy = 1'b0;
    logic            wr_req = 1'b0;
    logic [ADDR-1:0] wr_addr = '0;
    logic [DATA-1:0] wr_data = '0;
    logic            wr_gnt;
    logic            rd_req = 1'b0;
    logic [ADDR-1:0] rd_addr = '0;
    logic            rd_gnt;
    logic            rd_vld;
    logic [DATA-1:0] rd_data;
    logic            CEN, WEN;
    logic [ADDR-1:0] A;
    logic [DATA-1:0] D;
    logic [DATA-1:0] Q = '0;
    logic            err_addr;
    logic            err_clr = 1'b0;

    sram_sp_arbiter #(.ADDR(ADDR), .DEPTH(DEPTH), .DATA(DATA)) dut (
        .CLK(CLK), .rst(rst), .mbist_busy(mbist_busy),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_vld(rd_vld), .rd_data(rd_data),
        .CEN(CEN), .WEN(WEN), .A(A), .D(D), .Q(Q),
        .err_addr(err_addr), .err_clr(err_clr)
    );

    always #5 CLK = ~CLK;

    // Behavioural SRAM: Q valid the cycle after the read command cycle.
    logic [DATA-1:0] mem [0:4095];
    always @(posedge CLK) begin
        if (!CEN) begin
            if (!WEN) mem[A] <= D;
            else      Q <= mem[A];
        end
    end

    typedef struct {
        int              cyc;
        logic            cen;
        logic            wen;
        logic [ADDR-1:0] a;
        logic [DATA-1:0] d;
    } cmd_t;

    typedef struct {
        int              due;
        logic [DATA-1:0] data;
    } rd_t;

    cmd_t cmdq[$];
    rd_t  rdq[$];
    logic [DATA-1:0] shadow [0:DEPTH-1];
    logic            exp_err = 1'b0;
    logic [DATA-1:0] last_rd = '0;
    int cyc_n = 0;
    int checks = 0;
    int failures = 0;

    always @(posedge CLK) cyc_n <= cyc_n + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc_n, act, exp);
        end
    endfunction

    always @(negedge CLK) begin
        cmd_t c;
        rd_t  r;
        if (rst) begin
            chk("rst_cen", CEN, 1);
            chk("rst_wen", WEN, 1);
            chk("rst_a", A, 0);
            chk("rst_d", D, 0);
            chk("rst_rd_vld", rd_vld, 0);
            chk("rst_rd_data", rd_data, 0);
            chk("rst_err", err_addr, 0);
            chk("rst_wr_gnt", wr_gnt, 0);
            chk("rst_rd_gnt", rd_gnt, 0);
            last_rd = '0;
        end else begin
            if (cmdq.size() > 0 && cmdq[0].cyc == cyc_n) begin
                c = cmdq.pop_front();
            end else begin
                c = '{cyc: cyc_n, cen: 1'b1, wen: 1'b1, a: '0, d: '0};
            end
            chk("pin_cen", CEN, c.cen);
            chk("pin_wen", WEN, c.wen);
            chk("pin_a", A, c.a);
            chk("pin_d", D, c.d);
            if (rd_vld) begin
                if (rdq.size() == 0) begin
                    chk("rd_vld_unexpected", 1, 0);
                end else begin
                    r = rdq.pop_front();
                    chk("rd_latency", cyc_n, r.due);
                    chk("rd_data", rd_data, r.data);
                end
                last_rd = rd_data;
            end else begin
                chk("rd_data_hold", rd_data, last_rd);
                if (rdq.size() > 0 && rdq[0].due < cyc_n) begin
                    r = rdq.pop_front();
                    chk("rd_vld_missing", 0, 1);
                end
            end
            chk("err_addr", err_addr, exp_err);
        end
    end

    // eg: expected grant this cycle, 0 none, 1 write, 2 read.
    task automatic step(input logic w, input logic [ADDR-1:0] wa, input logic [DATA-1:0] wd,
                        input logic r, input logic [ADDR-1:0] ra, input logic mb,
                        input logic clr, input int eg);
        logic err_set;
        err_set    = 1'b0;
        wr_req     = w;
        wr_addr    = wa;
        wr_data    = wd;
        rd_req     = r;
        rd_addr    = ra;
        mbist_busy = mb;
        err_clr    = clr;
        @(negedge CLK);
        chk("wr_gnt", wr_gnt, (eg == 1));
        chk("rd_gnt", rd_gnt, (eg == 2));
        if (eg == 1) begin
            if (wa < DEPTH) begin
                cmdq.push_back('{cyc: cyc_n + 1, cen: 1'b0, wen: 1'b0, a: wa, d: wd});
                shadow[wa] = wd;
            end else begin
                err_set = 1'b1;
            end
        end else if (eg == 2) begin
            if (ra < DEPTH) begin
                cmdq.push_back('{cyc: cyc_n + 1, cen: 1'b0, wen: 1'b1, a: ra, d: '0});
                rdq.push_back('{due: cyc_n + 3, data: shadow[ra]});
            end else begin
                rdq.push_back('{due: cyc_n + 3, data: '0});
                err_set = 1'b1;
            end
        end
        @(posedge CLK);
        if (err_set)  exp_err = 1'b1;
        else if (clr) exp_err = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asserted just after a clock edge; released after two edges. Leaves the bench in the
    // cycle in which reset drops, when no grant may be issued.
    task automatic do_reset();
        wr_req = 1'b1;
        rd_req = 1'b1;
        rst    = 1'b1;
        cmdq.delete();
        rdq.delete();
        exp_err = 1'b0;
        #1;
        chk("async_cen", CEN, 1);
        chk("async_a", A, 0);
        chk("async_rd_gnt", rd_gnt, 0);
        repeat (2) @(posedge CLK);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        @(posedge CLK);
        #1;
        do_reset();
        step(1, 0, 0, 1, 0, 0, 0, 0);          // reset-release cycle: no grant

        // Write 5 then read 5.
        step(1, 5, 40'hA5A5A5A5A5, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 5, 0, 0, 2);
        idle(4);

        // Contention after reset: R W R W R W.
        do_reset();
        step(1, 10, 40'h1, 1, 11, 0, 0, 0);
        step(1, 10, 40'h1, 1, 11, 0, 0, 2);
        step(1, 12, 40'h2, 1, 11, 0, 0, 1);
        step(1, 13, 40'h3, 1, 12, 0, 0, 2);
        step(1, 13, 40'h3, 1, 13, 0, 0, 1);
        step(1, 14, 40'h4, 1, 13, 0, 0, 2);
        step(1, 14, 40'h4, 1, 14, 0, 0, 1);
        idle(4);

        // Out-of-range read, clear, then clear colliding with a new error.
        step(0, 0, 0, 1, 12'd2336, 0, 0, 2);
        idle(3);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 12'd4000, 40'h77, 0, 0, 0, 1, 1);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 1, 0);

        // mbist_busy after a read grant; last stays read, so the next tie goes to write.
        step(0, 0, 0, 1, 12, 0, 0, 2);
        step(1, 20, 40'h20, 1, 13, 1, 0, 0);
        step(1, 20, 40'h20, 1, 13, 1, 0, 0);
        step(1, 20, 40'h20, 1, 13, 1, 0, 0);
        step(1, 20, 40'h20, 1, 13, 0, 0, 1);
        step(0, 0, 0, 1, 20, 0, 0, 2);
        idle(4);

        // Reset one cycle after a read grant: the read must vanish.
        step(0, 0, 0, 1, 5, 0, 0, 2);
        do_reset();
        step(1, 30, 40'h30, 1, 5, 0, 0, 0);
        step(1, 30, 40'h30, 1, 5, 0, 0, 2);
        step(1, 30, 40'h30, 0, 0, 0, 0, 1);
        idle(4);

        // Full-depth sweep.
        for (int i = 0; i < DEPTH; i++) step(1, ADDR'(i), DATA'(i), 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, ADDR'(i), 0, 0, 2);
        idle(5);
        chk("rdq_drained", rdq.size(), 0);
        chk("sweep_err", err_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
